// File: rtl/game_tick_pkg.sv
// Shared types and helpers for the multi-channel game tick: default period,
// loader state encoding and the period clamp.
package game_tick_pkg;

  typedef enum logic [0:0] {
    LD_IDLE = 1'b0,
    LD_PEND = 1'b1
  } ld_state_e;

  function automatic int default_div(input int clk_hz, input int step_hz);
    return clk_hz / step_hz;
  endfunction

  function automatic logic [31:0] clamp_min(input logic [31:0] v, input logic [31:0] lo);
    if (v < lo) begin
      return lo;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/tick_channel.sv
// One tick channel: programmable-period divider, registered tick pulse and
// wrapping tick counter. Period load has priority over a speed-up step.
module tick_channel
  import game_tick_pkg::*;
#(
  parameter int               DIV_W    = 24,
  parameter int               CNT_W    = 16,
  parameter int               MIN_DIV  = 2,
  parameter int               DEC_STEP = 1_000_000,
  parameter logic [DIV_W-1:0] DIV_RST  = DIV_W'(5_000_000)
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             restart,
  input  logic             speedup,
  input  logic             load,
  input  logic [DIV_W-1:0] load_div,
  output logic             wrap,
  output logic             tick,
  output logic [CNT_W-1:0] tick_count
);

  localparam logic [DIV_W-1:0] MIN_V  = DIV_W'(MIN_DIV);
  localparam logic [DIV_W-1:0] DEC_V  = DIV_W'(DEC_STEP);
  localparam logic [DIV_W-1:0] SAT_TH = MIN_V + DEC_V;

  logic [DIV_W-1:0] cnt_r;
  logic [DIV_W-1:0] div_r;
  logic [DIV_W-1:0] spd_div_s;
  logic             wrap_s;
  logic             tick_r;
  logic [CNT_W-1:0] count_r;

  // Compare is >= so a period shortened below the current count wraps at once.
  assign wrap_s = run & ~restart & (cnt_r >= (div_r - DIV_W'(1)));

  // Saturating speed-up: never step below the minimum legal period.
  always_comb begin
    spd_div_s = div_r;
    if (div_r < SAT_TH) begin
      spd_div_s = MIN_V;
    end else begin
      spd_div_s = div_r - DEC_V;
    end
  end

  // Divider, tick pulse and tick counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r   <= '0;
      div_r   <= DIV_RST;
      tick_r  <= 1'b0;
      count_r <= '0;
    end else begin
      tick_r <= wrap_s;
      if (restart) begin
        cnt_r   <= '0;
        count_r <= '0;
      end else if (wrap_s) begin
        cnt_r   <= '0;
        count_r <= count_r + CNT_W'(1);
      end else if (run) begin
        cnt_r <= cnt_r + DIV_W'(1);
      end
      if (load) begin
        div_r <= load_div;
      end else if (speedup) begin
        div_r <= spd_div_s;
      end
    end
  end

  assign wrap       = wrap_s;
  assign tick       = tick_r;
  assign tick_count = count_r;

endmodule

// File: rtl/game_tick_multi.sv
// NCH independent programmable game-tick channels with pause/restart fan-out
// and a valid/ready period loader that applies new periods only at safe points.
module game_tick_multi
  import game_tick_pkg::*;
#(
  parameter int NCH      = 2,
  parameter int CLK_HZ   = 25_000_000,
  parameter int STEP_HZ  = 5,
  parameter int DIV_W    = 24,
  parameter int MIN_DIV  = 2,
  parameter int DEC_STEP = 1_000_000,
  parameter int CNT_W    = 16,
  parameter int CH_W     = (NCH > 1) ? $clog2(NCH) : 1
)(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NCH-1:0]     en,
  input  logic               pause,
  input  logic               restart,
  input  logic [NCH-1:0]     speedup,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [CH_W-1:0]    cfg_ch,
  input  logic [DIV_W-1:0]   cfg_div,
  output logic [NCH-1:0]     tick,
  output logic [NCH*CNT_W-1:0] tick_count
);

  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(default_div(CLK_HZ, STEP_HZ));

  ld_state_e        state_r;
  logic             cfg_ready_r;
  logic [CH_W-1:0]  ld_ch_r;
  logic             ld_ok_r;
  logic [DIV_W-1:0] ld_div_r;
  logic [NCH-1:0]   run_s;
  logic [NCH-1:0]   wrap_s;
  logic [NCH-1:0]   load_s;
  logic             ld_done_s;

  assign run_s = en & {NCH{~pause}};

  // A pending load lands at a wrap, on a stopped channel, or on restart.
  always_comb begin
    load_s = '0;
    for (int i = 0; i < NCH; i++) begin
      load_s[i] = (state_r == LD_PEND) & ld_ok_r & (ld_ch_r == CH_W'(i)) &
                  (wrap_s[i] | ~run_s[i] | restart);
    end
    ld_done_s = (state_r == LD_PEND) & (~ld_ok_r | (|load_s));
  end

  // Loader FSM: out-of-range channels are accepted and dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= LD_IDLE;
      cfg_ready_r <= 1'b1;
      ld_ch_r     <= '0;
      ld_ok_r     <= 1'b0;
      ld_div_r    <= DIV_RST;
    end else begin
      case (state_r)
        LD_IDLE: begin
          if (cfg_valid) begin
            state_r     <= LD_PEND;
            cfg_ready_r <= 1'b0;
            ld_ch_r     <= cfg_ch;
            ld_ok_r     <= ({1'b0, cfg_ch} < (CH_W + 1)'(NCH));
            ld_div_r    <= DIV_W'(clamp_min(32'(cfg_div), 32'(MIN_DIV)));
          end
        end
        LD_PEND: begin
          if (ld_done_s) begin
            state_r     <= LD_IDLE;
            cfg_ready_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= LD_IDLE;
          cfg_ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign cfg_ready = cfg_ready_r;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    tick_channel #(
      .DIV_W    (DIV_W),
      .CNT_W    (CNT_W),
      .MIN_DIV  (MIN_DIV),
      .DEC_STEP (DEC_STEP),
      .DIV_RST  (DIV_RST)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .run        (run_s[g]),
      .restart    (restart),
      .speedup    (speedup[g]),
      .load       (load_s[g]),
      .load_div   (ld_div_r),
      .wrap       (wrap_s[g]),
      .tick       (tick[g]),
      .tick_count (tick_count[g*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_game_tick_multi.sv
// Directed bench for game_tick_multi: 100 Hz clock model, 10 Hz default rate,
// so every channel starts with a 10-cycle period.
module tb_game_tick_multi;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  en, speedup, tick;
  logic        pause, restart, cfg_valid, cfg_ready, cfg_ch;
  logic [7:0]  cfg_div;
  logic [15:0] tick_count;

  logic [2:0]  en3, spd3, tick3;
  logic        p3, r3, cfg_valid3, cfg_ready3;
  logic [1:0]  cfg_ch3;
  logic [7:0]  cfg_div3;
  logic [23:0] tc3;

  int checks = 0;
  int fails = 0;

  always #5 clk = ~clk;

  game_tick_multi #(.NCH(2), .CLK_HZ(100), .STEP_HZ(10), .DIV_W(8), .MIN_DIV(2),
                    .DEC_STEP(3), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .pause(pause), .restart(restart),
    .speedup(speedup), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .tick(tick), .tick_count(tick_count));

  game_tick_multi #(.NCH(3), .CLK_HZ(100), .STEP_HZ(10), .DIV_W(8), .MIN_DIV(2),
                    .DEC_STEP(3), .CNT_W(8)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .en(en3), .pause(p3), .restart(r3),
    .speedup(spd3), .cfg_valid(cfg_valid3), .cfg_ready(cfg_ready3),
    .cfg_ch(cfg_ch3), .cfg_div(cfg_div3), .tick(tick3), .tick_count(tc3));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Cycles until tick[ch] is seen (counting from the next edge), -1 on timeout.
  task automatic wait_tick(input int ch, input int lim, output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!tick[ch] && n < lim);
    if (!tick[ch]) n = -1;
  endtask

  task automatic cfg_req(input logic ch, input logic [7:0] d);
    cfg_valid = 1'b1; cfg_ch = ch; cfg_div = d;
    cyc();
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    en = 2'b00; speedup = 2'b00; pause = 1'b0; restart = 1'b0;
    cfg_valid = 1'b0; cfg_ch = 1'b0; cfg_div = 8'd0;
    en3 = 3'b000; spd3 = 3'b000; p3 = 1'b0; r3 = 1'b0;
    cfg_valid3 = 1'b0; cfg_ch3 = 2'd0; cfg_div3 = 8'd0;
    rst_n = 1'b0;
    cyc(); cyc();
    checks++; if (tick !== 2'b00) begin $display("FAIL reset_tick: got %b want 00", tick); fails++; end
    checks++; if (tick_count !== 16'h0000) begin $display("FAIL reset_count: got %h want 0000", tick_count); fails++; end
    checks++; if (cfg_ready !== 1'b1) begin $display("FAIL reset_ready: got %b want 1", cfg_ready); fails++; end
    rst_n = 1'b1;
    cyc(); cyc();
    checks++; if (tick !== 2'b00) begin $display("FAIL idle_tick: got %b want 00", tick); fails++; end
  endtask

  task automatic test_default_rate();
    int n;
    en = 2'b11;
    wait_tick(0, 40, n);
    checks++; if (n !== 10) begin $display("FAIL first_tick: got %0d want 10", n); fails++; end
    checks++; if (tick !== 2'b11) begin $display("FAIL both_tick: got %b want 11", tick); fails++; end
    wait_tick(0, 40, n);
    checks++; if (n !== 10) begin $display("FAIL period10: got %0d want 10", n); fails++; end
    checks++; if (tick_count !== 16'h0202) begin $display("FAIL count2: got %h want 0202", tick_count); fails++; end
  endtask

  task automatic test_cfg_mid();
    int n;
    logic seen;
    cyc(); cyc(); cyc();
    cfg_req(1'b0, 8'd4);
    checks++; if (cfg_ready !== 1'b0) begin $display("FAIL pend_ready: got %b want 0", cfg_ready); fails++; end
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin cyc(); seen = seen | (|tick); end
    checks++; if (seen !== 1'b0 || cfg_ready !== 1'b0) begin $display("FAIL no_truncate: tick_seen %b ready %b want 0 0", seen, cfg_ready); fails++; end
    cyc();
    checks++; if (tick !== 2'b11 || cfg_ready !== 1'b1) begin $display("FAIL load_at_wrap: tick %b ready %b want 11 1", tick, cfg_ready); fails++; end
    wait_tick(0, 40, n);
    checks++; if (n !== 4) begin $display("FAIL new_period_a: got %0d want 4", n); fails++; end
    wait_tick(0, 40, n);
    checks++; if (n !== 4) begin $display("FAIL new_period_b: got %0d want 4", n); fails++; end
    wait_tick(1, 40, n);
    checks++; if (n !== 2) begin $display("FAIL ch1_unchanged: got %0d want 2", n); fails++; end
  endtask

  task automatic test_speedup();
    int n;
    int exp_a[3] = '{3, 1, 1};
    int exp_b[3] = '{4, 2, 2};
    for (int i = 0; i < 8; i++) cyc();
    speedup = 2'b10; cyc(); speedup = 2'b00;
    checks++; if (tick[1] !== 1'b0) begin $display("FAIL spd_no_early: got %b want 0", tick[1]); fails++; end
    cyc();
    checks++; if (tick[1] !== 1'b1) begin $display("FAIL spd_wrap_now: got %b want 1", tick[1]); fails++; end
    wait_tick(1, 40, n);
    checks++; if (n !== 7) begin $display("FAIL spd_period7: got %0d want 7", n); fails++; end
    for (int k = 0; k < 3; k++) begin
      speedup = 2'b10; cyc(); speedup = 2'b00;
      wait_tick(1, 40, n);
      checks++; if (n !== exp_a[k]) begin $display("FAIL spd_first_%0d: got %0d want %0d", k, n, exp_a[k]); fails++; end
      wait_tick(1, 40, n);
      checks++; if (n !== exp_b[k]) begin $display("FAIL spd_period_%0d: got %0d want %0d", k, n, exp_b[k]); fails++; end
    end
  endtask

  task automatic test_pause();
    int n;
    logic seen;
    logic [15:0] saved;
    wait_tick(0, 40, n);
    cyc(); cyc();
    saved = tick_count;
    pause = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin cyc(); seen = seen | (|tick); end
    cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_div = 8'd5;
    cyc(); cfg_valid = 1'b0; seen = seen | (|tick);
    checks++; if (cfg_ready !== 1'b0) begin $display("FAIL pause_pend: got %b want 0", cfg_ready); fails++; end
    cyc(); seen = seen | (|tick);
    checks++; if (cfg_ready !== 1'b1) begin $display("FAIL pause_load_fast: got %b want 1", cfg_ready); fails++; end
    for (int i = 0; i < 13; i++) begin cyc(); seen = seen | (|tick); end
    checks++; if (seen !== 1'b0) begin $display("FAIL pause_no_tick: got %b want 0", seen); fails++; end
    checks++; if (tick_count !== saved) begin $display("FAIL pause_count: got %h want %h", tick_count, saved); fails++; end
    pause = 1'b0;
    wait_tick(0, 40, n);
    checks++; if (n !== 2) begin $display("FAIL resume_phase: got %0d want 2", n); fails++; end
    wait_tick(1, 40, n);
    wait_tick(1, 40, n);
    checks++; if (n !== 5) begin $display("FAIL pause_loaded: got %0d want 5", n); fails++; end
  endtask

  task automatic test_restart();
    int n;
    wait_tick(0, 40, n);
    cfg_req(1'b0, 8'd3);
    checks++; if (cfg_ready !== 1'b0) begin $display("FAIL rst_pend: got %b want 0", cfg_ready); fails++; end
    restart = 1'b1; cyc(); restart = 1'b0;
    checks++; if (tick !== 2'b00) begin $display("FAIL restart_tick: got %b want 00", tick); fails++; end
    checks++; if (tick_count !== 16'h0000) begin $display("FAIL restart_count: got %h want 0000", tick_count); fails++; end
    checks++; if (cfg_ready !== 1'b1) begin $display("FAIL restart_load: got %b want 1", cfg_ready); fails++; end
    wait_tick(0, 40, n);
    checks++; if (n !== 3) begin $display("FAIL restart_ch0: got %0d want 3", n); fails++; end
    checks++; if (tick_count[7:0] !== 8'd1) begin $display("FAIL restart_cnt0: got %0d want 1", tick_count[7:0]); fails++; end
    wait_tick(1, 40, n);
    checks++; if (n !== 2) begin $display("FAIL restart_ch1: got %0d want 2", n); fails++; end
    checks++; if (tick_count[15:8] !== 8'd1) begin $display("FAIL restart_cnt1: got %0d want 1", tick_count[15:8]); fails++; end
  endtask

  task automatic test_clamp();
    int n;
    en = 2'b10;
    cfg_req(1'b0, 8'd0);
    checks++; if (cfg_ready !== 1'b0) begin $display("FAIL clamp_pend: got %b want 0", cfg_ready); fails++; end
    cyc();
    checks++; if (cfg_ready !== 1'b1) begin $display("FAIL clamp_stopped: got %b want 1", cfg_ready); fails++; end
    en = 2'b11;
    wait_tick(0, 40, n);
    wait_tick(0, 40, n);
    checks++; if (n !== 2) begin $display("FAIL clamp_div: got %0d want 2", n); fails++; end
  endtask

  task automatic test_bad_channel();
    int n;
    cfg_valid3 = 1'b1; cfg_ch3 = 2'd3; cfg_div3 = 8'd4;
    cyc(); cfg_valid3 = 1'b0;
    checks++; if (cfg_ready3 !== 1'b0) begin $display("FAIL bad_ch_accept: got %b want 0", cfg_ready3); fails++; end
    cyc();
    checks++; if (cfg_ready3 !== 1'b1) begin $display("FAIL bad_ch_idle: got %b want 1", cfg_ready3); fails++; end
    en3 = 3'b111;
    n = 0;
    do begin cyc(); n++; end while (!tick3[0] && n < 40);
    checks++; if (n !== 10 || tick3 !== 3'b111) begin $display("FAIL bad_ch_ignored: cycles %0d tick %b want 10 111", n, tick3); fails++; end
  endtask

  task automatic test_reset_pend();
    int n;
    wait_tick(0, 40, n);
    cfg_req(1'b0, 8'd9);
    checks++; if (cfg_ready !== 1'b0) begin $display("FAIL rp_pend: got %b want 0", cfg_ready); fails++; end
    rst_n = 1'b0; #1;
    checks++; if (cfg_ready !== 1'b1 || tick !== 2'b00 || tick_count !== 16'h0000) begin
      $display("FAIL rp_defaults: ready %b tick %b count %h want 1 00 0000", cfg_ready, tick, tick_count); fails++; end
    cyc();
    rst_n = 1'b1;
    wait_tick(0, 40, n);
    checks++; if (n !== 10) begin $display("FAIL rp_first: got %0d want 10", n); fails++; end
    wait_tick(0, 40, n);
    checks++; if (n !== 10) begin $display("FAIL rp_period: got %0d want 10", n); fails++; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_default_rate();
    test_cfg_mid();
    test_speedup();
    test_pause();
    test_restart();
    test_clamp();
    test_bad_channel();
    test_reset_pend();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
